// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sprite image codes, the sprite scheduler FSM
// encoding and the signed offset helpers used for sprite hit tests.
package vga_pkg;

  localparam int HACTIVE = 1280;
  localparam int HTOTAL  = 1600;
  localparam int VACTIVE = 480;
  localparam int VTOTAL  = 525;
  localparam int SPR_DIM = 32;

  typedef enum logic [1:0] {IMG_PLANE, IMG_CHOPPER, IMG_BATTLESHIP} img_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_DONE} fsm_t;

  // Offset of a pixel/line from the sprite's top-left corner (centre - 16),
  // in 11-bit signed arithmetic so sprites straddling an edge clip correctly.
  function automatic logic signed [10:0] spr_offset(input logic [9:0] pos,
                                                    input logic [9:0] centre);
    return $signed({1'b0, pos} - ({1'b0, centre} - 11'd16));
  endfunction

  // True when the offset lies inside the 32-pixel sprite extent.
  function automatic logic in_box(input logic signed [10:0] off);
    return off[10:5] == 6'd0;
  endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_row_buffer.sv
// One sprite row: 32 pixels of 4-bit colour, written during blanking and
// read combinationally during active video.
module sprite_row_buffer (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [3:0] wdata,
  input  logic [4:0] raddr,
  output logic [3:0] rdata
);

  logic [3:0] mem [32];

  // Single synchronous write port fed by the ROM return path.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares the sprite ROM among NSLOTS slots: prefetches next line's sprite rows
// during horizontal blanking, then priority-resolves sprite colour per pixel.
module sprite_fetch_scheduler
  import vga_pkg::*;
#(
  parameter int NSLOTS = 3,
  parameter int NIMG   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  input  logic [NSLOTS*10-1:0]  slot_x,
  input  logic [NSLOTS*10-1:0]  slot_y,
  input  logic [NSLOTS*5-1:0]   slot_img,
  output logic [1:0]            rom_sel,
  output logic [9:0]            rom_addr,
  input  logic [3:0]            rom_q,
  output logic [3:0]            spr_color,
  output logic                  spr_valid
);

  localparam int KW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  logic [NSLOTS*10-1:0] sh_x, sh_y;
  logic [NSLOTS*5-1:0]  sh_img;
  logic [NSLOTS-1:0]    row_valid;
  fsm_t                 state, state_nx;
  logic [KW-1:0]        k_r;
  logic [4:0]           row_r, col_r;
  logic [1:0]           sel_r;
  logic [9:0]           next_line, cur_y, px;
  logic [4:0]           cur_img;
  logic signed [10:0]   row_off;
  logic                 hit, last_slot, win_start, no_fetch;
  logic                 vld_p1;
  logic [4:0]           col_p1;
  logic [KW-1:0]        k_p1;
  logic [NSLOTS-1:0]    opaque;
  logic [NSLOTS*4-1:0]  slot_color;
  logic [3:0]           win_color;
  logic                 win_any;

  assign next_line = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
  assign win_start = (hcount == 11'(HACTIVE));
  assign no_fetch  = (next_line >= 10'(VACTIVE));
  assign cur_y     = sh_y[10*k_r +: 10];
  assign cur_img   = sh_img[5*k_r +: 5];
  assign row_off   = spr_offset(next_line, {1'b0, cur_y[9:1]});
  assign hit       = cur_y[0] && (cur_img < 5'(NIMG)) && in_box(row_off);
  assign last_slot = (k_r == KW'(NSLOTS - 1));
  assign rom_sel   = sel_r;
  assign rom_addr  = {row_r, col_r};
  assign px        = hcount[10:1];

  // Snapshot slot registers once per frame so mid-frame writes never tear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_img <= '0;
    end else if (win_start && vcount == 10'(VACTIVE)) begin
      sh_x   <= slot_x;
      sh_y   <= slot_y;
      sh_img <= slot_img;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Fetch FSM next state: walk every slot once per blanking window.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_start) state_nx = no_fetch ? S_DONE : S_CHECK;
      S_CHECK: begin
        if (hit)            state_nx = S_FETCH;
        else if (last_slot) state_nx = S_DONE;
      end
      S_FETCH: if (col_r == 5'd31) state_nx = S_DRAIN;
      S_DRAIN: state_nx = last_slot ? S_DONE : S_CHECK;
      S_DONE:  if (hcount == 11'd0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Slot index, ROM address counters and per-slot row validity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r       <= '0;
      row_r     <= '0;
      col_r     <= '0;
      sel_r     <= '0;
      row_valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_start) begin
            k_r <= '0;
            if (no_fetch) row_valid <= '0;
          end
        end
        S_CHECK: begin
          if (hit) begin
            row_r <= row_off[4:0];
            col_r <= 5'd0;
            sel_r <= cur_img[1:0];
          end else begin
            row_valid[k_r] <= 1'b0;
            if (!last_slot) k_r <= k_r + KW'(1);
          end
        end
        S_FETCH: if (col_r != 5'd31) col_r <= col_r + 5'd1;
        S_DRAIN: begin
          row_valid[k_r] <= 1'b1;
          if (!last_slot) k_r <= k_r + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // Stage p1: ROM data returns one clock after the address; track its slot/column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= (state == S_FETCH);
  end

  // Stage p1 data tags travel unreset alongside vld_p1.
  always_ff @(posedge clk) begin
    col_p1 <= col_r;
    k_p1   <= k_r;
  end

  for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
    logic signed [10:0] px_off;
    logic [3:0]         rdata;

    assign px_off = spr_offset(px, sh_x[10*k +: 10]);

    sprite_row_buffer u_buf (
      .clk   (clk),
      .we    (vld_p1 && (k_p1 == KW'(k))),
      .waddr (col_p1),
      .wdata (rom_q),
      .raddr (px_off[4:0]),
      .rdata (rdata)
    );

    assign opaque[k]          = row_valid[k] && in_box(px_off) && (rdata != 4'd0);
    assign slot_color[4*k +: 4] = rdata;
  end

  // Lowest-numbered slot with an opaque pixel wins.
  always_comb begin
    win_color = 4'd0;
    win_any   = 1'b0;
    for (int k = NSLOTS - 1; k >= 0; k--) begin
      if (opaque[k]) begin
        win_color = slot_color[4*k +: 4];
        win_any   = 1'b1;
      end
    end
  end

  // Display output stage: registered one clock after the pixel's hcount.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spr_color <= 4'd0;
      spr_valid <= 1'b0;
    end else if (hcount < 11'(HACTIVE) && win_any) begin
      spr_color <= win_color;
      spr_valid <= 1'b1;
    end else begin
      spr_color <= 4'd0;
      spr_valid <= 1'b0;
    end
  end

endmodule
